// File: rtl/run_sched_pkg.sv
// run_sched_pkg: shared definitions for the run scheduler and the run/count
// worker FSMs.
//   - state_e   : IDLE / RUN / LAST encoding (STATE_W bits)
//   - clamp_len : maps a requested run length of 0 to 1
package run_sched_pkg;

    localparam int STATE_W   = 2;
    // Widest run-length field clamp_len accepts; callers zero-extend into it
    // and truncate the result back to their own counter width.
    localparam int LEN_MAX_W = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_e;

    function automatic logic [LEN_MAX_W-1:0] clamp_len(input logic [LEN_MAX_W-1:0] len);
        return (len == '0) ? LEN_MAX_W'(1) : len;
    endfunction

endpackage

// File: rtl/run_sched_if.sv
// run_sched_if: requester-side bundle of the run scheduler.
//   req     : NREQ   level request per requester
//   len     : CNT_W  run length for the next granted run
//   grant   : NREQ   one-hot grant, high during RUN
//   done    : NREQ   one-cycle completion pulse on the winner's bit
//   done_id : ID_W   index of the current / just-finished winner
//   busy    : 1      scheduler not idle
// Optional (RUN_SCHED_ABORT_EN defined):
//   abort   : 1      cut the current run short
//   aborted : 1      high with done when the run was cut short
// Modports: master = requester side, slave = scheduler side.
interface run_sched_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]  req;
    logic [CNT_W-1:0] len;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic [ID_W-1:0]  done_id;
    logic             busy;

`ifdef RUN_SCHED_ABORT_EN
    logic abort;
    logic aborted;

    modport master (output req, len, abort, input grant, done, done_id, busy, aborted);
    modport slave  (input req, len, abort, output grant, done, done_id, busy, aborted);
`else
    modport master (output req, len, input grant, done, done_id, busy);
    modport slave  (input req, len, output grant, done, done_id, busy);
`endif

endinterface

// File: rtl/run_sched_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req : NREQ  request vector
//   ptr : ID_W  last winner; the search starts at ptr+1 (mod NREQ)
//   win : ID_W  index of the first set request found
//   any : 1     at least one request is set (win is valid only then)
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win,
    output logic            any
);

    logic [ID_W-1:0] w_idx;

    // Walk from the lowest priority (ptr+NREQ == ptr) up to the highest
    // (ptr+1); the last hit overwrites earlier ones and so has priority.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        win   = '0;
        w_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = ID_W'((int'(ptr) + i) % NREQ);
            if (req[w_idx]) begin
                win = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/run_sched.sv
// run_sched: non-preemptive round-robin scheduler sharing one counted-run
// resource among NREQ requesters. Arbitrates in IDLE, grants the winner for
// max(len,1) cycles in RUN, pulses done in LAST, then re-arbitrates.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : run_sched_if.slave (req/len in, grant/done/done_id/busy out)
// Optional feature macro: RUN_SCHED_ABORT_EN adds bus.abort / bus.aborted;
// abort in RUN forces LAST at the next edge.
// NREQ/CNT_W must match the parameters of the connected interface.
module run_sched
    import run_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    run_sched_if.slave   bus
);

    localparam int              ID_W = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE  = NREQ'(1);

    state_e            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, r_len_q;
    logic [ID_W-1:0]   r_win, r_ptr, w_win_next, w_pick;
    logic [NREQ-1:0]   r_grant, r_done;
    logic              r_busy;
    logic              w_any, w_cnt_last, w_abort;
    logic [CNT_W-1:0]  w_load_len;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .win (w_pick),
        .any (w_any)
    );

`ifdef RUN_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort     = bus.abort;
    assign bus.aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign w_cnt_last = (r_cnt == r_len_q - CNT_W'(1));
    assign w_load_len = CNT_W'(clamp_len(LEN_MAX_W'(bus.len)));

    always_comb begin
        w_next     = r_state;
        w_win_next = r_win;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next     = RUN;
                    w_win_next = w_pick;
                end
            end
            RUN:     if (w_cnt_last || w_abort) w_next = LAST;
            LAST:    w_next = IDLE;
            default: w_next = IDLE;   // unreachable encodings recover to IDLE
        endcase
    end

    // grant/done/busy are registered from the next state so they line up
    // with the state they describe, with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_win     <= '0;
            r_ptr     <= ID_W'(NREQ - 1);
            r_cnt     <= '0;
            r_len_q   <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
`ifdef RUN_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_next;
            r_win   <= w_win_next;
            r_grant <= (w_next == RUN)  ? (ONE << w_win_next) : '0;
            r_done  <= (w_next == LAST) ? (ONE << r_win)      : '0;
            r_busy  <= (w_next != IDLE);
            if (r_state == IDLE && w_any) begin
                r_len_q <= w_load_len;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == LAST) begin
                r_ptr <= r_win;
            end
`ifdef RUN_SCHED_ABORT_EN
            // A run that reaches its natural end on the abort cycle is not
            // reported as aborted.
            r_aborted <= (r_state == RUN) && w_abort && !w_cnt_last;
`endif
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.done_id = r_win;
    assign bus.busy    = r_busy;

endmodule
